// File: rtl/simd_carry_in_manager.sv
// simd_carry_in_manager: per-lane 8-way carry-in select with 0-3 stage CARRYIN pipe, optional round register and serial config chain.
// Optional macro CARRYIN_INVERT_EN adds a per-lane CARRYIN inversion bit to the chain.
module simd_carry_in_manager #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RSTALLCARRYIN,
    input  logic               CECARRYIN,
    input  logic               CEM,
    input  logic [LANES-1:0]   CARRYIN,
    input  logic [LANES-1:0]   A_mult_msb,
    input  logic [LANES-1:0]   B_mult_msb,
    input  logic [LANES-1:0]   PCIN_msb,
    input  logic [LANES-1:0]   P_msb,
    input  logic [LANES-1:0]   CARRYCASCIN,
    input  logic [LANES-1:0]   CARRYCASCOUT,
    input  logic [3*LANES-1:0] CARRYINSEL,
    output logic [LANES-1:0]   CIN,
    input  logic               configuration_input,
    input  logic               configuration_enable,
    output logic               configuration_output
);
`ifdef CARRYIN_INVERT_EN
    localparam int LB = 4;
`else
    localparam int LB = 3;
`endif
    localparam int CFG_N = 1 + LANES * LB;
    logic [CFG_N-1:0] cfg;
    logic [LANES-1:0] inv, cin_x, xnr, s1, s2, s3, r;
    logic rstx;
    assign configuration_output = cfg[0];
    assign rstx = RSTALLCARRYIN ^ cfg[0];
    assign cin_x = CARRYIN ^ inv;
    assign xnr = ~(A_mult_msb ^ B_mult_msb);
    // Data registers keep running while the chain shifts; only rst touches cfg.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg <= '0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            r <= '0;
        end else begin
            if (configuration_enable) cfg <= {configuration_input, cfg[CFG_N-1:1]};
            if (rstx) begin
                s1 <= '0;
                s2 <= '0;
                s3 <= '0;
                r <= '0;
            end else begin
                if (CECARRYIN) begin
                    s1 <= cin_x;
                    s2 <= s1;
                    s3 <= s2;
                end
                if (CEM) r <= xnr;
            end
        end
    end
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int B = 1 + i * LB;
`ifdef CARRYIN_INVERT_EN
        assign inv[i] = cfg[B+3];
`else
        assign inv[i] = 1'b0;
`endif
        logic [1:0] d;
        logic [2:0] sel;
        logic tap, rnd, c;
        always_comb begin
            d = cfg[B+1:B];
            sel = CARRYINSEL[3*i +: 3];
            tap = d == 2'd0 ? cin_x[i] : d == 2'd1 ? s1[i] : d == 2'd2 ? s2[i] : s3[i];
            rnd = cfg[B+2] ? r[i] : xnr[i];
            case (sel)
                3'd0: c = tap;
                3'd1: c = ~PCIN_msb[i];
                3'd2: c = CARRYCASCIN[i];
                3'd3: c = PCIN_msb[i];
                3'd4: c = CARRYCASCOUT[i];
                3'd5: c = ~P_msb[i];
                3'd6: c = rnd;
                default: c = P_msb[i];
            endcase
        end
        assign CIN[i] = c;
    end
endmodule
